// File: rtl/mult_div_unit.sv
// mult_div_unit
// Sequential signed multiply/divide unit for the multicycle MIPS datapath.
// One bit is processed per clock: shift-add multiply (LSB first) and
// restoring divide (MSB first) on operand magnitudes. Signs are fixed
// up in a final cycle. HI/LO are architectural state held here.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   start_mult begin a * b (sampled in IDLE only, wins over start_div)
//   start_div  begin a / b (sampled in IDLE only)
//   a, b       operands, sampled on the start edge
//   hi, lo     HI/LO registers (product upper/lower, or remainder/quotient)
//   busy       operation in progress
//   done       one-cycle pulse when a result is written or a divide aborts
//   div_zero   one-cycle pulse with done for a divide by zero
//
// state | meaning
// IDLE  | waiting for start_mult / start_div
// CALC  | one multiply or divide iteration per clock, WIDTH iterations
// FIX   | sign correction and HI/LO write, done pulses next cycle
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               neg_q;     // result (product or quotient) negative
  logic               neg_r;     // dividend negative -> remainder negative
  logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   opq;       // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [2*WIDTH-1:0] acc;       // product register
  logic [WIDTH-1:0]   rem;       // partial remainder, always < divisor

  logic               go_mult, go_div, go_dz, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Unsigned negate gives |-2^(WIDTH-1)| = 2^(WIDTH-1) correctly.
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opq[0] ? opb : '0)};
  assign rem_shift = {rem, opq[WIDTH-1]};
  // Since rem < divisor, rem_diff[WIDTH] is exactly the borrow of the trial subtract.
  assign rem_diff  = rem_shift - {1'b0, opb};

  assign prod_fix = neg_q ? -acc : acc;
  assign quot_fix = neg_q ? -opq : opq;
  assign rem_fix  = neg_r ? -rem : rem;

  always_comb begin
    go_mult   = start_mult;
    go_div    = start_div & ~start_mult & (b != '0);
    go_dz     = start_div & ~start_mult & (b == '0);
    last_iter = (cnt == CW'(WIDTH - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (go_mult || go_div) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opb      <= '0;
      opq      <= '0;
      acc      <= '0;
      rem      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (go_mult || go_div) begin
            op_div <= go_div;
            opb    <= mag_b;
            opq    <= mag_a;
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r  <= a[WIDTH-1];
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end else if (go_dz) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op_div) begin
            if (!rem_diff[WIDTH]) begin
              rem <= rem_diff[WIDTH-1:0];
              opq <= {opq[WIDTH-2:0], 1'b1};
            end else begin
              rem <= rem_shift[WIDTH-1:0];
              opq <= {opq[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
            opq <= {1'b0, opq[WIDTH-1:1]};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (op_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (WIDTH = 32): directed vector table, random
// operations against a plain-arithmetic model, and protocol corner sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sm;
    bit          sd;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] eh;
    logic [31:0] el;
    bit          edz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Architectural result from signed arithmetic; HI/LO kept on divide by zero.
  task automatic ref_op(input bit sm, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ph, input logic [31:0] pl,
                        output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    h = ph; l = pl; dz = 1'b0;
    if (sm) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (bv == 32'd0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle so a
  // following call starts back-to-back.
  task automatic do_op(input string nm, input bit sm, input bit sd,
                       input logic [31:0] av, input logic [31:0] bv, input bit glitch,
                       input logic [31:0] eh, input logic [31:0] el, input bit edz);
    int c, busy_n;
    bit seen, dz_any;
    a = av; b = bv; start_mult = sm; start_div = sd;
    @(negedge clk);
    start_mult = 0; start_div = 0;
    a = $urandom; b = $urandom;
    c = 0; busy_n = 0; seen = 0; dz_any = 0;
    while (c < 100) begin
      if (busy) busy_n++;
      if (div_zero) dz_any = 1;
      if (done) begin
        seen = 1;
        break;
      end
      if (c == 16) begin
        chk({nm, " hold_hi"}, {32'd0, hi}, {32'd0, model_hi});
        chk({nm, " hold_lo"}, {32'd0, lo}, {32'd0, model_lo});
      end
      if (glitch && c == 5) begin start_div = 1; b = 32'd0; end
      if (glitch && c == 6) start_div = 0;
      @(negedge clk);
      c++;
    end
    chk({nm, " done_seen"}, 64'(seen), 64'd1);
    chk({nm, " latency"}, 64'(c), edz ? 64'd0 : 64'd33);
    chk({nm, " busy_cycles"}, 64'(busy_n), edz ? 64'd0 : 64'd33);
    chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    chk({nm, " div_zero"}, 64'(div_zero), 64'(edz));
    chk({nm, " dz_during"}, 64'(dz_any), 64'(edz));
    model_hi = eh;
    model_lo = el;
  endtask

  initial begin
    logic [31:0] rh, rl, ra, rb;
    bit          rdz, rsm;
    int          k;

    vecs[0] = '{1, 0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0};
    vecs[1] = '{1, 0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 0};
    vecs[2] = '{0, 1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0};
    vecs[3] = '{0, 1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};
    vecs[4] = '{0, 1, 32'h56781234,  32'h00010000, 32'h00001234, 32'h00005678, 0};
    vecs[5] = '{0, 1, 32'h00000063,  32'h00000000, 32'h00001234, 32'h00005678, 1};
    vecs[6] = '{1, 1, 32'd6,         32'd7,        32'h00000000, 32'h0000002A, 0};
    vecs[7] = '{0, 1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0};

    reset = 1; start_mult = 0; start_div = 0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].sm, vecs[i].sd, vecs[i].av, vecs[i].bv, 0,
            vecs[i].eh, vecs[i].el, vecs[i].edz);
    end

    // start_div pulse (with b = 0) while a multiply runs must be ignored
    do_op("glitch", 1, 0, 32'd100, 32'hFFFFFFFB, 1, 32'hFFFFFFFF, 32'hFFFFFE0C, 0);

    // reset at iteration 10 of a multiply
    a = 32'h00012345; b = 32'h00054321; start_mult = 1;
    @(negedge clk);
    start_mult = 0;
    repeat (10) @(negedge clk);
    chk("midrst busy_before", 64'(busy), 64'd1);
    reset = 1;
    #1;
    chk("midrst hi", {32'd0, hi}, 64'd0);
    chk("midrst lo", {32'd0, lo}, 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset = 0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    ref_op(1, 32'd12345, 32'hFFFFFC18, model_hi, model_lo, rh, rl, rdz);
    do_op("after_reset", 1, 0, 32'd12345, 32'hFFFFFC18, 0, rh, rl, rdz);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 7);
      rsm = (k < 4);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      case ($urandom_range(0, 9))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'h80000000;
        default: ;
      endcase
      if (k == 7) rb = 32'd0;
      ref_op(rsm, ra, rb, model_hi, model_lo, rh, rl, rdz);
      do_op($sformatf("rand%0d", i), rsm, ~rsm, ra, rb, 0, rh, rl, rdz);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
